// File: rtl/uart_pkg.sv
// Shared definitions for the rc UART transmitter and receiver: FSM state
// encoding, default bit period and the w/a/s/d command byte constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // 50 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam logic [7:0] CMD_W = 8'h77;
    localparam logic [7:0] CMD_A = 8'h61;
    localparam logic [7:0] CMD_S = 8'h73;
    localparam logic [7:0] CMD_D = 8'h64;

    // Even parity: the bit that makes the total count of ones even
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and
// wraps; bit_done is high during the last cycle of each bit period. The
// clear input holds the counter at zero so every frame starts on a fresh
// period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk_50,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Free-running bit-period counter, held at zero while cleared
    always_ff @(posedge clk_50) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_done = (cnt == LAST);

endmodule

// File: rtl/rc_uart_tx.sv
// rc_uart_tx: 8N1 UART transmitter for the rc command link. Accepts a byte
// on a valid/ready handshake and shifts it out LSB first between a start
// and a stop bit. All outputs are registered.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after
// the eighth data bit (11-bit frame); undefined gives plain 8N1.
module rc_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_out
);

    uart_state_t state, state_nx;
    logic [7:0]  shreg, shreg_nx;
    logic [2:0]  bit_idx, bit_idx_nx;
    logic        tx_out_nx;
    logic        bit_done;
    logic        accept;
`ifdef UART_TX_PARITY_EN
    logic        par_bit, par_nx;
`endif

    assign accept = tx_valid && tx_ready;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_50   (clk_50),
        .rst      (rst),
        .clear    (state == IDLE),
        .bit_done (bit_done)
    );

    // Next-state, next serial bit and shift-register update
    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_idx_nx = bit_idx;
        tx_out_nx  = tx_out;
`ifdef UART_TX_PARITY_EN
        par_nx     = par_bit;
`endif
        case (state)
            IDLE: begin
                tx_out_nx  = 1'b1;
                bit_idx_nx = 3'd0;
                if (accept) begin
                    state_nx  = START;
                    shreg_nx  = tx_data;
                    tx_out_nx = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_nx    = even_parity(tx_data);
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_nx   = DATA;
                    tx_out_nx  = shreg[0];
                    shreg_nx   = {1'b0, shreg[7:1]};
                    bit_idx_nx = 3'd0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nx  = PARITY;
                        tx_out_nx = par_bit;
`else
                        state_nx  = STOP;
                        tx_out_nx = 1'b1;
`endif
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                        tx_out_nx  = shreg[0];
                        shreg_nx   = {1'b0, shreg[7:1]};
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_nx  = STOP;
                    tx_out_nx = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_nx  = IDLE;
                    tx_out_nx = 1'b1;
                end
            end
            default: begin
                state_nx  = IDLE;
                tx_out_nx = 1'b1;
            end
        endcase
    end

    // Control state and registered outputs; reset aborts any frame in flight
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state    <= IDLE;
            tx_out   <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            bit_idx  <= 3'd0;
        end else begin
            state    <= state_nx;
            tx_out   <= tx_out_nx;
            tx_ready <= (state_nx == IDLE);
            tx_busy  <= (state_nx != IDLE);
            bit_idx  <= bit_idx_nx;
        end
    end

    // Frame payload; contents are don't-care until the next accept
    always_ff @(posedge clk_50) begin
        shreg   <= shreg_nx;
`ifdef UART_TX_PARITY_EN
        par_bit <= par_nx;
`endif
    end

endmodule

// File: tb/tb_rc_uart_tx.sv
// Self-checking bench for rc_uart_tx at CLKS_PER_BIT=4, plus a second
// instance at the default bit period to measure the start-bit width.
module tb_rc_uart_tx;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk_50 = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_busy, tx_out;

    logic [7:0] d2_data;
    logic       d2_valid;
    logic       d2_ready, d2_busy, d2_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_50 = ~clk_50;

    rc_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk_50   (clk_50),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx_out   (tx_out)
    );

    rc_uart_tx dut2 (
        .clk_50   (clk_50),
        .rst      (rst),
        .tx_data  (d2_data),
        .tx_valid (d2_valid),
        .tx_ready (d2_ready),
        .tx_busy  (d2_busy),
        .tx_out   (d2_out)
    );

    // Reference: serial level of frame bit i for byte b
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (NB == 11 && i == 9) begin
            int ones = 0;
            for (int k = 0; k < 8; k++) ones += int'(b[k]);
            return (ones % 2) == 1;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge just after accept: checks every cycle of the
    // frame, decodes the byte from mid-bit samples, then checks the idle cycle.
    // poke >= 0 pulses tx_valid with 8'h73 at that cycle and scrambles tx_data.
    task automatic expect_frame(input logic [7:0] b, input string tag, input int poke);
        logic [7:0] dec;
        dec = 8'h00;
        for (int i = 0; i < NB * N; i++) begin
            if (poke >= 0 && i == poke) begin
                tx_valid = 1'b1;
                tx_data  = 8'h73;
            end else if (poke >= 0 && i == poke + 1) begin
                tx_valid = 1'b0;
                tx_data  = 8'($urandom);
            end
            chk({tag, "_line"}, 32'(tx_out), 32'(frame_bit(b, i / N)));
            chk({tag, "_ready"}, 32'(tx_ready), 32'd0);
            if (i % N == 0) chk({tag, "_busy"}, 32'(tx_busy), 32'd1);
            if (i % N == N / 2 && i / N >= 1 && i / N <= 8) dec[i / N - 1] = tx_out;
            @(negedge clk_50);
        end
        chk({tag, "_idle_line"}, 32'(tx_out), 32'd1);
        chk({tag, "_idle_ready"}, 32'(tx_ready), 32'd1);
        chk({tag, "_idle_busy"}, 32'(tx_busy), 32'd0);
        chk({tag, "_decoded"}, 32'(dec), 32'(b));
    endtask

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk_50);
        @(negedge clk_50);
        tx_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int cnt;

        // Reset held three cycles
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        d2_valid = 1'b0;
        d2_data  = 8'h00;
        repeat (3) @(posedge clk_50);
        @(negedge clk_50);
        chk("reset_line", 32'(tx_out), 32'd1);
        chk("reset_ready", 32'(tx_ready), 32'd1);
        chk("reset_busy", 32'(tx_busy), 32'd0);
        chk("reset_d2_line", 32'(d2_out), 32'd1);
        rst = 1'b0;
        @(negedge clk_50);
        chk("post_reset_line", 32'(tx_out), 32'd1);

        // Single 'w' frame: 40 busy cycles, then ready
        send(8'h77);
        expect_frame(8'h77, "w", -1);

        // Back-to-back with tx_valid held: 'a' then 'd', one idle cycle apart
        tx_data  = 8'h61;
        tx_valid = 1'b1;
        @(posedge clk_50);
        @(negedge clk_50);
        tx_data  = 8'h64;
        expect_frame(8'h61, "b2b_a", -1);
        @(negedge clk_50);
        tx_valid = 1'b0;
        expect_frame(8'h64, "b2b_d", -1);

        // Valid pulse mid-frame is ignored; tx_data changes do not leak in
        send(8'h77);
        expect_frame(8'h77, "ignore", 17);
        for (int i = 0; i < 2 * N; i++) begin
            chk("ignore_quiet_line", 32'(tx_out), 32'd1);
            chk("ignore_quiet_ready", 32'(tx_ready), 32'd1);
            @(negedge clk_50);
        end

        // Reset during DATA bit 3 aborts the frame
        b = 8'($urandom);
        send(b);
        for (int i = 0; i < 4 * N + 2; i++) begin
            chk("abort_line", 32'(tx_out), 32'(frame_bit(b, i / N)));
            @(negedge clk_50);
        end
        rst = 1'b1;
        @(negedge clk_50);
        chk("abort_line_high", 32'(tx_out), 32'd1);
        chk("abort_ready", 32'(tx_ready), 32'd1);
        chk("abort_busy", 32'(tx_busy), 32'd0);
        rst = 1'b0;
        b = 8'($urandom);
        send(b);
        expect_frame(b, "after_abort", -1);

        // Random bytes with random idle gaps
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk_50);
            b = 8'($urandom);
            send(b);
            expect_frame(b, "rand", -1);
        end

        // Default bit period: start bit lasts 434 cycles
        d2_data  = 8'h77;
        d2_valid = 1'b1;
        @(posedge clk_50);
        @(negedge clk_50);
        d2_valid = 1'b0;
        cnt = 0;
        while (d2_out == 1'b0 && cnt < 2000) begin
            cnt++;
            @(negedge clk_50);
        end
        chk("d2_start_width", 32'(cnt), 32'd434);
        cnt = 0;
        while (d2_ready != 1'b1 && cnt < 10000) begin
            cnt++;
            @(negedge clk_50);
        end
        chk("d2_ready_return", 32'(d2_ready), 32'd1);
        chk("d2_idle_line", 32'(d2_out), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
